elastic_pr: RTL and testbench

ELASTIC_PR -- requirements
Module: elastic_pr

---
 rtl/elastic_pr.sv | 107 ++++++++++
 tb/tb_elastic_pr.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/elastic_pr.sv
// Elastic register pipeline with bubble collapse, optional input skid buffer,
// stall/flush control and a registered occupancy count.
module elastic_pr #(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned STAGES = 2,
    parameter int unsigned SKID   = 1
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               in_valid,
    output logic                               in_ready,
    input  logic [WIDTH-1:0]                   in_data,
    output logic                               out_valid,
    input  logic                               out_ready,
    output logic [WIDTH-1:0]                   out_data,
    input  logic                               stall,
    input  logic                               flush,
    output logic [$clog2(STAGES+SKID+1)-1:0]   occupancy
);
    localparam int unsigned OW       = $clog2(STAGES + SKID + 1);
    localparam bit          HAS_SKID = (SKID != 0);

    logic [STAGES-1:0] valid_q, valid_d, load;
    logic [WIDTH-1:0]  data_q [STAGES];
    logic [WIDTH-1:0]  data_d [STAGES];
    logic              skid_valid_q, skid_valid_d;
    logic [WIDTH-1:0]  skid_data_q, skid_data_d;
    logic [OW-1:0]     occ_q, occ_d;
    logic              in_xfer, out_xfer;

    // Load enables ripple from the output end: a stage may load when it is
    // empty or when everything downstream of it is moving.
    always_comb begin : ctrl
        logic        room;
        int unsigned idx;
        room = out_ready & ~flush;
        idx  = 0;
        load = '0;
        for (int unsigned k = 0; k < STAGES; k++) begin
            idx       = STAGES - 1 - k;
            load[idx] = ~stall & (~valid_q[idx] | room);
            room      = load[idx];
        end
        out_xfer = valid_q[STAGES-1] & out_ready & ~stall & ~flush;
        if (HAS_SKID) begin
            in_ready = ~rst & ~stall & ~skid_valid_q;
        end else begin
            in_ready = ~rst & ~stall & load[0];
        end
        in_xfer = in_valid & in_ready;
    end

    always_comb begin : nxt
        valid_d      = valid_q;
        data_d       = data_q;
        skid_valid_d = skid_valid_q;
        skid_data_d  = skid_data_q;
        occ_d        = occ_q + OW'(in_xfer) - OW'(out_xfer);
        for (int unsigned i = 1; i < STAGES; i++) begin
            if (load[i]) begin
                valid_d[i] = valid_q[i-1];
                data_d[i]  = data_q[i-1];
            end
        end
        // A held skid entry always wins stage 0; in_ready is low while it is held.
        if (load[0]) begin
            if (skid_valid_q) begin
                valid_d[0]   = 1'b1;
                data_d[0]    = skid_data_q;
                skid_valid_d = 1'b0;
            end else begin
                valid_d[0] = in_xfer;
                data_d[0]  = in_data;
            end
        end else if (HAS_SKID && in_xfer) begin
            skid_valid_d = 1'b1;
            skid_data_d  = in_data;
        end
        if (flush) begin
            valid_d      = '0;
            skid_valid_d = 1'b0;
            occ_d        = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q      <= '0;
            skid_valid_q <= 1'b0;
            occ_q        <= '0;
        end else begin
            valid_q      <= valid_d;
            skid_valid_q <= skid_valid_d;
            occ_q        <= occ_d;
        end
    end

    always_ff @(posedge clk) begin
        data_q      <= data_d;
        skid_data_q <= skid_data_d;
    end

    assign out_valid = valid_q[STAGES-1];
    assign out_data  = data_q[STAGES-1];
    assign occupancy = occ_q;

endmodule

// File: tb/tb_elastic_pr.sv
// Directed and random checks of elastic_pr against a queue-based FIFO model.
module tb_elastic_pr;
    localparam int unsigned WIDTH  = 8;
    localparam int unsigned STAGES = 2;
    localparam int unsigned SKID   = 1;
    localparam int unsigned CAP    = STAGES + SKID;

    logic             clk;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic             stall;
    logic             flush;
    logic [$clog2(STAGES+SKID+1)-1:0] occupancy;

    elastic_pr #(.WIDTH(WIDTH), .STAGES(STAGES), .SKID(SKID)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .stall(stall), .flush(flush), .occupancy(occupancy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_assert = 0;
    int          n_fail   = 0;
    int          n_out    = 0;
    int unsigned cyc      = 0;
    bit          known    = 0;
    logic [WIDTH-1:0] q[$];
    int unsigned      acc[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: check outputs against the model just before the edge, then
    // apply the edge to the model. Returns #1 after the rising edge.
    task automatic step();
        bit exp_rdy;
        @(negedge clk);
        exp_rdy = !rst && !stall && (q.size() < CAP);
        if (known) begin
            chk("in_ready", in_ready, exp_rdy);
            chk("occupancy", occupancy, q.size());
            if (q.size() == 0) begin
                chk("out_valid_empty", out_valid, 0);
            end else if (out_valid === 1'b1) begin
                chk("out_data", out_data, q[0]);
                chk("latency", (cyc >= acc[0] + STAGES), 1);
            end
        end
        if (rst) begin
            q.delete(); acc.delete(); known = 1;
        end else if (flush) begin
            q.delete(); acc.delete();
        end else begin
            if (out_valid && out_ready && !stall && q.size() > 0) begin
                void'(q.pop_front()); void'(acc.pop_front()); n_out++;
            end
            if (in_valid && in_ready) begin
                q.push_back(in_data); acc.push_back(cyc);
            end
        end
        cyc++;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        int base;
        logic [WIDTH-1:0] d0;
        rst = 1; in_valid = 0; in_data = '0; out_ready = 0; stall = 0; flush = 0;
        step(); step();
        rst = 0;
        #1;
        chk("reset_out_valid", out_valid, 0);
        chk("reset_occupancy", occupancy, 0);
        chk("post_reset_in_ready", in_ready, 1);

        // Single entry latency: push in cycle 5, visible in cycle 7.
        out_ready = 1;
        repeat (5) step();
        in_valid = 1; in_data = 8'h11;
        step();
        in_valid = 0;
        chk("lat_c6_occ", occupancy, 1);
        chk("lat_c6_ov", out_valid, 0);
        step();
        chk("lat_c7_ov", out_valid, 1);
        chk("lat_c7_data", out_data, 8'h11);
        chk("lat_c7_occ", occupancy, 1);
        step();
        chk("lat_c8_occ", occupancy, 0);
        chk("lat_c8_ov", out_valid, 0);

        // Back-to-back stream of 16 values.
        base = n_out;
        for (int i = 0; i < 18; i++) begin
            in_valid = (i < 16);
            in_data  = 8'(i);
            if (i < 16) chk("stream_in_ready", in_ready, 1);
            step();
            if (i >= 1 && i <= 16) begin
                chk("stream_out_valid", out_valid, 1);
                chk("stream_out_data", out_data, 8'(i - 1));
            end
        end
        in_valid = 0;
        chk("stream_count", n_out - base, 16);

        // Fill with downstream blocked, then drain.
        out_ready = 0; k = 0; in_valid = 1;
        while (in_ready === 1'b1 && k < 8) begin
            in_data = 8'(8'h20 + k);
            step();
            k++;
        end
        in_valid = 0;
        chk("fill_count", k, CAP);
        chk("fill_occ", occupancy, CAP);
        base = n_out;
        out_ready = 1;
        repeat (4) step();
        chk("fill_drain_count", n_out - base, CAP);
        chk("fill_drain_occ", occupancy, 0);

        // Stall with two entries held.
        out_ready = 0; in_valid = 1;
        in_data = 8'h31; step();
        in_data = 8'h32; step();
        in_valid = 0;
        step(); step();
        stall = 1; out_ready = 1;
        d0 = out_data;
        chk("stall_head", d0, 8'h31);
        repeat (4) begin
            step();
            chk("stall_occ", occupancy, 2);
            chk("stall_out_data", out_data, 8'h31);
            chk("stall_out_valid", out_valid, 1);
            chk("stall_in_ready", in_ready, 0);
        end
        stall = 0;
        repeat (3) step();
        chk("stall_release_occ", occupancy, 0);

        // Flush a full pipe while offering 0xAA.
        out_ready = 0; in_valid = 1;
        for (int i = 0; i < 3; i++) begin
            in_data = 8'(8'h41 + i);
            step();
        end
        chk("flush_pre_occ", occupancy, 3);
        flush = 1; in_data = 8'hAA;
        step();
        flush = 0; in_valid = 0;
        chk("flush_occ", occupancy, 0);
        chk("flush_out_valid", out_valid, 0);
        out_ready = 1;
        repeat (4) step();

        // Mid-traffic reset, then random traffic.
        out_ready = 0; in_valid = 1;
        in_data = 8'h51; step();
        in_data = 8'h52; step();
        in_valid = 0;
        rst = 1;
        step();
        rst = 0;
        chk("midreset_out_valid", out_valid, 0);
        chk("midreset_occ", occupancy, 0);
        for (int i = 0; i < 600; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_data   = 8'($urandom);
            out_ready = ($urandom_range(0, 2) != 0);
            stall     = ($urandom_range(0, 7) == 0);
            flush     = ($urandom_range(0, 31) == 0);
            step();
        end
        in_valid = 0; stall = 0; flush = 0; out_ready = 1;
        repeat (6) step();
        chk("final_drain_occ", occupancy, 0);
        chk("final_out_valid", out_valid, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
